// File: rtl/multi_wf_instr_collate_if.sv
// Bus between the wavepool and the multi-wavefront instruction collation stage.
//   in_*      : one instruction dword per cycle, tagged with its wavefront id
//   flush_*   : discard the partial instruction held for one wavefront
//   out_*     : one complete, left-aligned instruction per cycle (registered)
//   pending   : per-wavefront "partial instruction held" flags
// Handshake: in_valid and flush_valid are plain qualifiers with no ready;
// the collator accepts every qualified dword/flush in the cycle it is
// presented, and out_valid is a one-cycle pulse downstream must consume.
// Modport slave is the collator, master is the wavepool/decode side.
interface multi_wf_instr_collate_if #(
    parameter int NUM_WF     = 40,
    parameter int WFID_W     = 6,
    parameter int MAX_DWORDS = 3,
    parameter int CNT_W      = 2
);
    logic                    in_valid;
    logic [WFID_W-1:0]       in_wfid;
    logic [31:0]             in_instr;
    logic [31:0]             in_pc;
    logic [CNT_W-1:0]        in_extra;
    logic                    flush_valid;
    logic [WFID_W-1:0]       flush_wfid;
    logic                    out_valid;
    logic [WFID_W-1:0]       out_wfid;
    logic [31:0]             out_pc;
    logic [32*MAX_DWORDS-1:0] out_instr;
    logic [CNT_W:0]          out_ndwords;
    logic                    out_long;
    logic                    out_err;
    logic [NUM_WF-1:0]       pending;

    modport slave (
        input  in_valid, in_wfid, in_instr, in_pc, in_extra, flush_valid, flush_wfid,
        output out_valid, out_wfid, out_pc, out_instr, out_ndwords, out_long, out_err, pending
    );

    modport master (
        output in_valid, in_wfid, in_instr, in_pc, in_extra, flush_valid, flush_wfid,
        input  out_valid, out_wfid, out_pc, out_instr, out_ndwords, out_long, out_err, pending
    );
endinterface

// File: rtl/multi_wf_instr_collate.sv
// Multi-wavefront instruction collation stage.
// Collects instruction dwords per wavefront in independent slots so dwords
// of different wavefronts may interleave, and emits each complete
// instruction (1..MAX_DWORDS dwords) as one registered left-aligned word.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : multi_wf_instr_collate_if.slave (input dwords, flush, outputs)
module multi_wf_instr_collate #(
    parameter int NUM_WF     = 40,
    parameter int WFID_W     = 6,
    parameter int MAX_DWORDS = 3,
    parameter int CNT_W      = 2
) (
    input  logic clk,
    input  logic rst,
    multi_wf_instr_collate_if.slave bus
);
    localparam int                SW        = MAX_DWORDS - 1;
    localparam int                OW        = 32 * MAX_DWORDS;
    localparam logic [WFID_W:0]   NUM_WF_L  = (WFID_W+1)'(NUM_WF);
    localparam logic [CNT_W-1:0]  MAX_EXTRA = CNT_W'(MAX_DWORDS - 1);

    // Per-slot state. cap = dwords stored so far, rem = dwords still needed.
    logic [NUM_WF-1:0] pend_q;
    logic [CNT_W-1:0]  cap_q   [NUM_WF];
    logic [CNT_W-1:0]  rem_q   [NUM_WF];
    logic [31:0]       pc_q    [NUM_WF];
    logic [31:0]       store_q [NUM_WF][SW];

    logic                  out_valid_q, out_long_q, out_err_q;
    logic [WFID_W-1:0]     out_wfid_q;
    logic [31:0]           out_pc_q;
    logic [OW-1:0]         out_instr_q;
    logic [CNT_W:0]        out_ndwords_q;

    logic                  in_ok, flush_ok, in_take, slot_pend, completes;
    logic [CNT_W-1:0]      asm_cap, sat_extra;
    logic [OW-1:0]         asm_word;
    logic [31:0]           asm_pc;

    always_comb begin
        in_ok     = bus.in_valid && ({1'b0, bus.in_wfid} < NUM_WF_L);
        flush_ok  = bus.flush_valid && ({1'b0, bus.flush_wfid} < NUM_WF_L);
        // A flush of the same slot in the same cycle wins; the dword is dropped.
        in_take   = in_ok && !(flush_ok && (bus.flush_wfid == bus.in_wfid));
        slot_pend = in_ok ? pend_q[bus.in_wfid] : 1'b0;
        asm_cap   = slot_pend ? cap_q[bus.in_wfid] : '0;
        asm_pc    = slot_pend ? pc_q[bus.in_wfid] : bus.in_pc;
        sat_extra = (bus.in_extra > MAX_EXTRA) ? MAX_EXTRA : bus.in_extra;
        completes = slot_pend ? (rem_q[bus.in_wfid] == CNT_W'(1))
                              : (bus.in_extra == '0);
        // Only positions below cap come from storage, so stale storage of an
        // idle slot never leaks into the zero-fill.
        asm_word = '0;
        for (int k = 0; k < SW; k++) begin
            if (CNT_W'(k) < asm_cap) asm_word[32*k +: 32] = store_q[bus.in_wfid][k];
        end
        for (int k = 0; k < MAX_DWORDS; k++) begin
            if (CNT_W'(k) == asm_cap) asm_word[32*k +: 32] = bus.in_instr;
        end
    end

    // Slot control and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q        <= '0;
            for (int w = 0; w < NUM_WF; w++) begin
                cap_q[w] <= '0;
                rem_q[w] <= '0;
            end
            out_valid_q   <= 1'b0;
            out_err_q     <= 1'b0;
            out_long_q    <= 1'b0;
            out_wfid_q    <= '0;
            out_pc_q      <= '0;
            out_instr_q   <= '0;
            out_ndwords_q <= '0;
        end else begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            if (flush_ok) begin
                pend_q[bus.flush_wfid] <= 1'b0;
                cap_q[bus.flush_wfid]  <= '0;
                rem_q[bus.flush_wfid]  <= '0;
            end
            if (in_take) begin
                if (completes) begin
                    out_valid_q   <= 1'b1;
                    out_wfid_q    <= bus.in_wfid;
                    out_pc_q      <= asm_pc;
                    out_instr_q   <= asm_word;
                    out_ndwords_q <= (CNT_W+1)'(asm_cap) + (CNT_W+1)'(1);
                    out_long_q    <= (asm_cap != '0);
                    pend_q[bus.in_wfid] <= 1'b0;
                    cap_q[bus.in_wfid]  <= '0;
                    rem_q[bus.in_wfid]  <= '0;
                end else if (!slot_pend) begin
                    pend_q[bus.in_wfid] <= 1'b1;
                    cap_q[bus.in_wfid]  <= CNT_W'(1);
                    rem_q[bus.in_wfid]  <= sat_extra;
                    out_err_q           <= (bus.in_extra > MAX_EXTRA);
                end else begin
                    cap_q[bus.in_wfid]  <= cap_q[bus.in_wfid] + CNT_W'(1);
                    rem_q[bus.in_wfid]  <= rem_q[bus.in_wfid] - CNT_W'(1);
                end
            end
        end
    end

    // Dword and pc storage need no reset: they are only read below cap.
    always_ff @(posedge clk) begin
        if (in_take && !completes) begin
            if (!slot_pend) begin
                store_q[bus.in_wfid][0] <= bus.in_instr;
                pc_q[bus.in_wfid]       <= bus.in_pc;
            end else begin
                store_q[bus.in_wfid][cap_q[bus.in_wfid]] <= bus.in_instr;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_wfid    = out_wfid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_ndwords = out_ndwords_q;
    assign bus.out_long    = out_long_q;
    assign bus.out_err     = out_err_q;
    assign bus.pending     = pend_q;
endmodule

// File: tb/tb_multi_wf_instr_collate.sv
module tb_multi_wf_instr_collate;
    localparam int NUM_WF     = 40;
    localparam int WFID_W     = 6;
    localparam int MAX_DWORDS = 3;
    localparam int CNT_W      = 2;
    localparam int OW         = 32 * MAX_DWORDS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_wf_instr_collate_if #(.NUM_WF(NUM_WF), .WFID_W(WFID_W),
        .MAX_DWORDS(MAX_DWORDS), .CNT_W(CNT_W)) bus ();

    multi_wf_instr_collate #(.NUM_WF(NUM_WF), .WFID_W(WFID_W),
        .MAX_DWORDS(MAX_DWORDS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // ---------------- behavioural model ----------------
    // Each wavefront keeps a list of received dwords and the total it needs.
    logic [NUM_WF-1:0]   m_pend;
    int                  m_need [NUM_WF];
    int                  m_have [NUM_WF];
    logic [31:0]         m_pcs  [NUM_WF];
    logic [31:0]         m_words[NUM_WF][MAX_DWORDS];
    logic                m_valid, m_err, m_long;
    logic [WFID_W-1:0]   m_wfid;
    logic [31:0]         m_pc;
    logic [OW-1:0]       m_instr;
    logic [CNT_W:0]      m_ndw;

    task automatic model_emit(input int w);
        m_valid = 1'b1;
        m_wfid  = WFID_W'(w);
        m_pc    = m_pcs[w];
        m_instr = '0;
        for (int k = 0; k < m_have[w]; k++) m_instr[32*k +: 32] = m_words[w][k];
        m_ndw   = (CNT_W+1)'(m_have[w]);
        m_long  = (m_have[w] > 1);
        m_pend[w] = 1'b0;
        m_have[w] = 0;
    endtask

    task automatic model_step(input logic r, input logic iv, input int iw,
                              input logic [31:0] ii, input logic [31:0] ip,
                              input int ie, input logic fv, input int fw);
        bit fl;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_pend = '0;
            for (int w = 0; w < NUM_WF; w++) m_have[w] = 0;
            m_long = 1'b0; m_wfid = '0; m_pc = '0; m_instr = '0; m_ndw = '0;
            return;
        end
        fl = fv && (fw < NUM_WF);
        if (fl) begin
            m_pend[fw] = 1'b0;
            m_have[fw] = 0;
        end
        if (iv && iw < NUM_WF && !(fl && fw == iw)) begin
            if (!m_pend[iw]) begin
                m_need[iw]     = 1 + ((ie > MAX_DWORDS - 1) ? MAX_DWORDS - 1 : ie);
                m_err          = (ie > MAX_DWORDS - 1);
                m_words[iw][0] = ii;
                m_pcs[iw]      = ip;
                m_have[iw]     = 1;
                if (m_need[iw] == 1) model_emit(iw);
                else m_pend[iw] = 1'b1;
            end else begin
                m_words[iw][m_have[iw]] = ii;
                m_have[iw] = m_have[iw] + 1;
                if (m_have[iw] == m_need[iw]) model_emit(iw);
            end
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, all outputs against the model.
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            check_val("out_valid",   128'(bus.out_valid),   128'(m_valid));
            check_val("out_err",     128'(bus.out_err),     128'(m_err));
            check_val("pending",     128'(bus.pending),     128'(m_pend));
            check_val("out_wfid",    128'(bus.out_wfid),    128'(m_wfid));
            check_val("out_pc",      128'(bus.out_pc),      128'(m_pc));
            check_val("out_instr",   128'(bus.out_instr),   128'(m_instr));
            check_val("out_ndwords", 128'(bus.out_ndwords), 128'(m_ndw));
            check_val("out_long",    128'(bus.out_long),    128'(m_long));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic iv, input int iw,
                         input logic [31:0] ii, input logic [31:0] ip, input int ie,
                         input logic fv, input int fw);
        @(negedge clk);
        rst             = r;
        bus.in_valid    = iv;
        bus.in_wfid     = WFID_W'(iw);
        bus.in_instr    = ii;
        bus.in_pc       = ip;
        bus.in_extra    = CNT_W'(ie);
        bus.flush_valid = fv;
        bus.flush_wfid  = WFID_W'(fw);
        model_step(r, iv, iw, ii, ip, ie, fv, fw);
        check_en = 1'b1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 0, 1'b0, 0);
    endtask

    // Wait until just after the edge that consumed the last driven inputs.
    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.in_valid = 1'b0; bus.in_wfid = '0; bus.in_instr = '0; bus.in_pc = '0;
        bus.in_extra = '0; bus.flush_valid = 1'b0; bus.flush_wfid = '0;
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        peek();
        check_val("rst_valid",   128'(bus.out_valid),   128'd0);
        check_val("rst_pending", 128'(bus.pending),     128'd0);
        check_val("rst_ndwords", 128'(bus.out_ndwords), 128'd0);

        // Single-dword instruction
        drive(1'b0, 1'b1, 3, 32'hBF810000, 32'h100, 0, 1'b0, 0);
        peek();
        check_val("single_valid", 128'(bus.out_valid), 128'd1);
        check_val("single_wfid",  128'(bus.out_wfid),  128'd3);
        check_val("single_instr", 128'(bus.out_instr), 128'h0000_0000_0000_0000_BF81_0000);
        check_val("single_ndw",   128'(bus.out_ndwords), 128'd1);
        check_val("single_long",  128'(bus.out_long),  128'd0);
        check_val("single_pend3", 128'(bus.pending[3]), 128'd0);

        // Interleaved three-dword and two-dword instructions
        drive(1'b0, 1'b1, 5, 32'hAAAA0000, 32'h200, 2, 1'b0, 0);
        drive(1'b0, 1'b1, 7, 32'hBBBB0000, 32'h300, 1, 1'b0, 0);
        drive(1'b0, 1'b1, 5, 32'hAAAA0001, 32'h0,   0, 1'b0, 0);
        drive(1'b0, 1'b1, 7, 32'hBBBB0001, 32'h0,   0, 1'b0, 0);
        peek();
        check_val("il_b_wfid",  128'(bus.out_wfid),    128'd7);
        check_val("il_b_instr", 128'(bus.out_instr),   128'h0000_0000_BBBB_0001_BBBB_0000);
        check_val("il_b_ndw",   128'(bus.out_ndwords), 128'd2);
        check_val("il_b_pc",    128'(bus.out_pc),      128'h300);
        check_val("il_pend5",   128'(bus.pending[5]),  128'd1);
        drive(1'b0, 1'b1, 5, 32'hAAAA0002, 32'h0, 0, 1'b0, 0);
        peek();
        check_val("il_a_instr", 128'(bus.out_instr),   128'hAAAA_0002_AAAA_0001_AAAA_0000);
        check_val("il_a_ndw",   128'(bus.out_ndwords), 128'd3);
        check_val("il_a_pc",    128'(bus.out_pc),      128'h200);
        check_val("il_a_pend5", 128'(bus.pending[5]),  128'd0);

        // Flush then new first dword
        drive(1'b0, 1'b1, 2, 32'h22220000, 32'h400, 1, 1'b0, 0);
        drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 2);
        drive(1'b0, 1'b1, 2, 32'h22229999, 32'h404, 0, 1'b0, 0);
        peek();
        check_val("flush_instr", 128'(bus.out_instr), 128'h0000_0000_0000_0000_2222_9999);
        check_val("flush_pc",    128'(bus.out_pc),    128'h404);
        check_val("flush_pend2", 128'(bus.pending[2]), 128'd0);
        // Flush and dword on the same wf: dword dropped
        drive(1'b0, 1'b1, 4, 32'h44440000, 32'h500, 3, 1'b1, 4);
        peek();
        check_val("flush_same_valid", 128'(bus.out_valid), 128'd0);
        check_val("flush_same_err",   128'(bus.out_err),   128'd0);

        // Saturation: extra 3 with MAX_DWORDS 3 saturates to 2 more dwords
        drive(1'b0, 1'b1, 9, 32'h99990000, 32'h600, 3, 1'b0, 0);
        peek();
        check_val("sat_err",   128'(bus.out_err),    128'd1);
        check_val("sat_pend9", 128'(bus.pending[9]), 128'd1);
        drive(1'b0, 1'b1, 9, 32'h99990001, 32'h0, 3, 1'b0, 0);
        drive(1'b0, 1'b1, 9, 32'h99990002, 32'h0, 0, 1'b0, 0);
        peek();
        check_val("sat_ndw", 128'(bus.out_ndwords), 128'd3);

        // Reset mid-collation
        drive(1'b0, 1'b1, 1, 32'h11110000, 32'h700, 2, 1'b0, 0);
        drive(1'b1, 1'b0, 0, 32'h0, 32'h0, 0, 1'b0, 0);
        peek();
        check_val("mrst_instr",   128'(bus.out_instr), 128'd0);
        check_val("mrst_pending", 128'(bus.pending),   128'd0);
        drive(1'b0, 1'b1, 1, 32'h1111AAAA, 32'h800, 0, 1'b0, 0);
        peek();
        check_val("mrst_single_valid", 128'(bus.out_valid),   128'd1);
        check_val("mrst_single_ndw",   128'(bus.out_ndwords), 128'd1);

        // Out-of-range id
        drive(1'b0, 1'b1, NUM_WF, 32'hDEAD0000, 32'h900, 0, 1'b0, 0);
        peek();
        check_val("oor_valid",   128'(bus.out_valid), 128'd0);
        check_val("oor_pending", 128'(bus.pending),   128'd0);

        // Randomised traffic over a small set of ids, including out-of-range ones
        for (int n = 0; n < 3000; n++) begin
            int pick, iw, fw;
            pick = $urandom_range(0, 9);
            iw   = (pick < 6) ? pick : ((pick == 6) ? NUM_WF - 1 : ((pick == 7) ? NUM_WF : 63));
            fw   = $urandom_range(0, 7);
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), iw,
                  $urandom, $urandom, $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0), fw);
        end
        idle();
        idle();
        peek();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
